rca_4bit: RTL and testbench
===========================

// Module: rca_4bit
// PURPOSE
//  Registered 4-bit ripple-carry adder: Sum/Cout = A + B + Cin, built as a chain of 1-bit full adders.
//  Leaf arithmetic block for datapaths needing a small unsigned add with carry-in/carry-out.
//  Inputs are sampled and the result registered on each rising clk edge.
// PARAMETERS
//  WIDTH  4  operand/sum width in bits; the default 4 is the required configuration.
// PORTS
//  clk   in   1      single clock; all state updates on the rising edge
//  rst   in   1      synchronous, active-high reset
//  A     in   WIDTH  operand A, unsigned
//  B     in   WIDTH  operand B, unsigned
//  Cin   in   1      carry into bit 0
//  Sum   out  WIDTH  registered sum bits [WIDTH-1:0]
//  Cout  out  1      registered carry out of bit WIDTH-1
//  V     out  1      registered signed overflow; present only with RCA_4BIT_OVF_EN
// BEHAVIOUR
//  - Full adder per bit i: s[i] = A[i]^B[i]^c[i]; c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]); c[0] = Cin.
//  - Carry ripples combinationally from bit 0 to bit WIDTH-1; no lookahead.
//  - {Cout,Sum} = A + B + Cin, exact, (WIDTH+1) bits; range 0..31 for WIDTH=4.
//  - Latency 1: inputs present before rising edge k appear on Sum/Cout after edge k.
//  - Outputs hold their value between edges; new inputs every cycle are accepted. No handshake.
//  - Reset: rst high at a rising edge -> Sum=0, Cout=0 (and V=0); rst has priority over the add.
//  - Reset mid-stream: result of the cycle in which rst is high is discarded.
//  - First valid result appears after the first edge with rst low.
//  - Wrap: 15+15+1=31 -> Sum=4'hF, Cout=1; 15+0+1=16 -> Sum=0, Cout=1.
//  - Zero: 0+0+0 -> Sum=0, Cout=0.
//  - X/Z on inputs are not handled; inputs must be driven.
// CONFIGURATION
//  RCA_4BIT_OVF_EN defined:
//    - Adds output V, registered with Sum/Cout.
//    - V = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement overflow of A+B+Cin.
//    - Reset value of V is 0.
//  RCA_4BIT_OVF_EN undefined:
//    - Port V does not exist.
//    - Sum/Cout behaviour is identical in both configurations.
// TESTING
//  - rst=1 for 2 cycles with A=9, B=3, Cin=1 -> Sum=0, Cout=0 while rst is high.
//  - After rst falls: A=9, B=3, Cin=1 -> Sum=13 (4'hD), Cout=0.
//  - A=9, B=3, Cin=0 -> Sum=12.
//  - A=13, B=1, Cin=0/1 -> Sum=14/15, Cout=0.
//  - A=9, B=12, Cin=0/1 -> Sum=5/6, Cout=1.
//  - A=1, B=8, Cin=1 -> Sum=10, Cout=0.
//  - A=14, B=7, Cin=0 -> Sum=5, Cout=1.
//  - A=15, B=15, Cin=1 -> Sum=15, Cout=1.
//  - A=15, B=0, Cin=1 -> Sum=0, Cout=1.
//  - Back-to-back inputs every cycle: each result lags its inputs by exactly 1 edge.
//  - rst asserted mid-stream -> outputs 0 on that edge; next edge shows the current inputs' sum.
//  - With RCA_4BIT_OVF_EN: A=7, B=1, Cin=0 -> V=1; A=9, B=12, Cin=0 -> V=1; A=9, B=3, Cin=1 -> V=0.
//  - Exhaustive sweep of all 512 {A,B,Cin} combinations vs. the reference model A+B+Cin.

Source files
------------

// File: rtl/rca_4bit.sv
// rca_4bit: registered ripple-carry adder, {Cout,Sum} = A + B + Cin.
// The carry ripples bit by bit through a chain of 1-bit full adders, with no
// lookahead. Sum, Cout (and V) are registered, so the result appears one
// clock edge after its inputs.
// Optional feature: define RCA_4BIT_OVF_EN to add the registered signed
// overflow output V.
// Reset is synchronous and active-high. It takes priority over the add.

module rca_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
`ifdef RCA_4BIT_OVF_EN
   output logic             Cout,
   output logic             V
`else
   output logic             Cout
`endif
);

   logic [WIDTH-1:0] sum_nxt;
   logic             cout_nxt;
   logic             carry;
`ifdef RCA_4BIT_OVF_EN
   logic             carry_msb;
   logic             v_nxt;
`endif

   // Full-adder chain: carry enters at bit 0 and ripples up to the MSB.
   always_comb begin
      sum_nxt = '0;
      carry   = Cin;
`ifdef RCA_4BIT_OVF_EN
      carry_msb = 1'b0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
`ifdef RCA_4BIT_OVF_EN
         if (i == WIDTH - 1) begin
            carry_msb = carry;
         end
`endif
         sum_nxt[i] = A[i] ^ B[i] ^ carry;
         carry      = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
      end
      cout_nxt = carry;
`ifdef RCA_4BIT_OVF_EN
      // Overflow occurs when the carry into the MSB differs from the carry out of it.
      v_nxt = carry ^ carry_msb;
`endif
   end

   // Result register. Reset wins over the add and clears all outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         Sum  <= '0;
         Cout <= 1'b0;
`ifdef RCA_4BIT_OVF_EN
         V    <= 1'b0;
`endif
      end else begin
         Sum  <= sum_nxt;
         Cout <= cout_nxt;
`ifdef RCA_4BIT_OVF_EN
         V    <= v_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rca_4bit.sv
// Testbench for rca_4bit. The driver applies inputs on the falling edge and
// queues the expected result. The monitor checks the outputs just after each
// rising edge.

module tb_rca_4bit;

   typedef struct packed {
      logic [3:0] sum;
      logic       cout;
      logic       v;
      logic [8:0] tag;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] A;
   logic [3:0] B;
   logic       Cin;
   logic [3:0] Sum;
   logic       Cout;
`ifdef RCA_4BIT_OVF_EN
   logic       V;
`endif

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   rca_4bit #(.WIDTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .Cin  (Cin),
      .Sum  (Sum),
`ifdef RCA_4BIT_OVF_EN
      .Cout (Cout),
      .V    (V)
`else
      .Cout (Cout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: unsigned total for Sum/Cout, signed range check for V.
   function automatic exp_t model(input logic r, input logic [3:0] a,
                                  input logic [3:0] b, input logic ci);
      exp_t e;
      int   total;
      int   stotal;
      total  = int'(a) + int'(b) + int'(ci);
      stotal = int'($signed(a)) + int'($signed(b)) + int'(ci);
      e.tag  = {a, b, ci};
      if (r) begin
         e.sum  = 4'd0;
         e.cout = 1'b0;
         e.v    = 1'b0;
      end else begin
         e.sum  = 4'(total % 16);
         e.cout = (total >= 16);
         e.v    = (stotal > 7) || (stotal < -8);
      end
      return e;
   endfunction

   task automatic drive(input logic r, input logic [3:0] a,
                        input logic [3:0] b, input logic ci);
      @(negedge clk);
      rst = r;
      A   = a;
      B   = b;
      Cin = ci;
      exp_q.push_back(model(r, a, b, ci));
   endtask

   // Directed cross-check of the model itself, against literal expected values.
   task automatic check_exp(input logic [3:0] a, input logic [3:0] b,
                            input logic ci, input logic [3:0] s, input logic co);
      exp_t e;
      e = model(1'b0, a, b, ci);
      n_checks++;
      if (e.sum !== s || e.cout !== co) begin
         n_fail++;
         $display("FAIL model a=%0d b=%0d cin=%0d got %0d/%0d want %0d/%0d",
                  a, b, ci, e.sum, e.cout, s, co);
      end
   endtask

   // Monitor: after every rising edge, pop one expected result and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (Sum !== e.sum) begin
               n_fail++;
               $display("FAIL sum in=%h actual=%h required=%h", e.tag, Sum, e.sum);
            end
            n_checks++;
            if (Cout !== e.cout) begin
               n_fail++;
               $display("FAIL cout in=%h actual=%b required=%b", e.tag, Cout, e.cout);
            end
`ifdef RCA_4BIT_OVF_EN
            n_checks++;
            if (V !== e.v) begin
               n_fail++;
               $display("FAIL v in=%h actual=%b required=%b", e.tag, V, e.v);
            end
`endif
         end
      end
   end

   initial begin
      rst = 1'b1;
      A   = 4'd9;
      B   = 4'd3;
      Cin = 1'b1;

      // Literal expected values from the directed cases.
      check_exp(4'd9,  4'd3,  1'b1, 4'd13, 1'b0);
      check_exp(4'd15, 4'd15, 1'b1, 4'd15, 1'b1);
      check_exp(4'd15, 4'd0,  1'b1, 4'd0,  1'b1);
      check_exp(4'd14, 4'd7,  1'b0, 4'd5,  1'b1);

      // Hold reset for two cycles while the inputs are driven.
      drive(1'b1, 4'd9, 4'd3, 1'b1);
      drive(1'b1, 4'd9, 4'd3, 1'b1);

      // Directed cases.
      drive(1'b0, 4'd9,  4'd3,  1'b1);
      drive(1'b0, 4'd9,  4'd3,  1'b0);
      drive(1'b0, 4'd13, 4'd1,  1'b0);
      drive(1'b0, 4'd13, 4'd1,  1'b1);
      drive(1'b0, 4'd9,  4'd12, 1'b0);
      drive(1'b0, 4'd9,  4'd12, 1'b1);
      drive(1'b0, 4'd1,  4'd8,  1'b1);
      drive(1'b0, 4'd14, 4'd7,  1'b0);
      drive(1'b0, 4'd15, 4'd15, 1'b1);
      drive(1'b0, 4'd15, 4'd0,  1'b1);
      drive(1'b0, 4'd0,  4'd0,  1'b0);
      drive(1'b0, 4'd7,  4'd1,  1'b0);

      // Reset asserted mid-stream, then the same inputs with reset released.
      drive(1'b1, 4'd11, 4'd6, 1'b1);
      drive(1'b0, 4'd11, 4'd6, 1'b1);

      // Randomized back-to-back inputs, with occasional reset.
      for (int i = 0; i < 200; i++) begin
         drive(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      // Exhaustive sweep over every {A,B,Cin} combination.
      for (int k = 0; k < 512; k++) begin
         drive(1'b0, 4'(k >> 5), 4'((k >> 1) & 15), 1'(k & 1));
      end

      // Let the monitor drain the queue, within a bounded number of cycles.
      for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
         @(posedge clk);
         #2;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
